mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit for the RISC-V core.

---
 rtl/mul_div_unit_if.sv | 15 +
 rtl/mul_div_unit.sv | 135 +++++++++++++
 tb/tb_mul_div_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the control unit and the iterative RV32M mul/div unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// WIDTH iterations per op, start/busy/done handshake with a registered result.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2:0]         op;
  logic               neg;
  logic               div_zero;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   result_r;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               start_neg;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_next;

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

  // Operand magnitudes and result sign, captured when a request is accepted.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (bus.funct3)
      3'b000, 3'b001: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:         a_signed = 1'b1;
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase
    a_neg = a_signed & bus.op_a[WIDTH-1];
    b_neg = b_signed & bus.op_b[WIDTH-1];
    a_mag = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    b_mag = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    // Remainder follows the dividend; everything else is the product of the signs.
    start_neg = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration. Divide keeps the partial remainder in acc's low half and shifts
  // quotient bits into the high half; the dividend streams out of mcand[WIDTH-1].
  always_comb begin
    trial    = {acc[WIDTH-1:0], mcand[WIDTH-1]};
    diff     = trial[WIDTH-1:0] - mplr;
    acc_next = acc;
    if (!op[2])
      acc_next = acc + (mplr[0] ? mcand : '0);
    else if (trial >= {1'b0, mplr})
      acc_next = {acc[2*WIDTH-2:WIDTH], 1'b1, diff};
    else
      acc_next = {acc[2*WIDTH-2:WIDTH], 1'b0, trial[WIDTH-1:0]};
  end

  always_comb begin
    prod     = neg ? (~acc_next + 1'b1) : acc_next;
    quot     = acc_next[2*WIDTH-1:WIDTH];
    rem      = acc_next[WIDTH-1:0];
    res_next = '0;
    unique case (op)
      3'b000:                 res_next = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res_next = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res_next = div_zero ? '1 : (neg ? (~quot + 1'b1) : quot);
      default:                res_next = neg ? (~rem + 1'b1) : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op       <= bus.funct3;
            neg      <= start_neg;
            div_zero <= (bus.op_b == '0);
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplr     <= b_mag;
            count    <= '0;
            busy_r   <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          if (!op[2])
            mplr <= mplr >> 1;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            result_r <= res_next;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver queues expected results from a 64-bit arithmetic
// reference model; a negedge monitor pops and compares result and latency on each done pulse.
module tb_mul_div_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  bit prev_done = 1'b0;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
    logic [2:0]  f;
  } exp_t;
  exp_t scb[$];

  mul_div_unit_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    up = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        check("done_single_cycle", {31'b0, prev_done}, 32'h0);
        if (scb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: got result %h with no op outstanding", bus.result);
        end else begin
          exp_t e;
          e = scb.pop_front();
          check($sformatf("result_f%0d", e.f), bus.result, e.res);
          check($sformatf("latency_f%0d", e.f), cyc, e.due);
        end
      end else if (scb.size() > 0 && cyc > scb[0].due) begin
        exp_t e;
        e = scb.pop_front();
        checks++; errors++;
        $display("FAIL timeout_f%0d: no done by cycle %0d, expected at %0d", e.f, cyc, e.due);
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Issue one op in IDLE, scramble the inputs after accept, optionally pulse start mid-CALC,
  // then wait through DONE plus 'gap' idle cycles.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int unsigned gap, input bit poke);
    int unsigned c0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    c0 = cyc;
    scb.push_back('{res: expv, due: c0 + W + 1, f: f});
    @(negedge clk);
    bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
    if (poke) begin
      while (cyc < c0 + 10) @(negedge clk);
      check("busy_mid_calc", {31'b0, bus.busy}, 32'h1);
      bus.start = 1'b1; bus.funct3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
    end
    while (cyc < c0 + W + 1 + gap) @(negedge clk);
  endtask

  logic [2:0]  dir_f [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] dir_a [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_r [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

  initial begin
    int unsigned c0;
    logic [31:0] ha, hb;
    bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;

    // Power-up reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_result", bus.result, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      issue(dir_f[i], dir_a[i], dir_b[i], dir_r[i], (i % 3 == 0) ? 0 : 2, i == 1);

    // Mid-operation reset discards the op and clears the result.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midop_rst_busy", {31'b0, bus.busy}, 32'h0);
    check("midop_rst_done", {31'b0, bus.done}, 32'h0);
    check("midop_rst_result", bus.result, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle_result", bus.result, 32'h0);

    // start held high: accepted every W+2 cycles.
    ha = pick(); hb = pick();
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd6; bus.op_a = ha; bus.op_b = hb;
    c0 = cyc;
    for (int k = 0; k < 3; k++)
      scb.push_back('{res: model(3'd6, ha, hb), due: c0 + W + 1 + k * (W + 2), f: 3'd6});
    while (cyc < c0 + W + 1 + 2 * (W + 2)) @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized ops against the reference model.
    for (int i = 0; i < 50; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = pick();
      b = pick();
      issue(f, a, b, model(f, a, b), $urandom_range(0, 3), (i % 7) == 3);
      check("result_held", bus.result, model(f, a, b));
    end

    for (int t = 0; t < 200 && scb.size() > 0; t++) @(negedge clk);
    if (scb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d ops still outstanding, expected 0", scb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
